// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared state encoding, ratio codes and counter width for div_rate_ctrl
package div_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  typedef enum logic [1:0] {DIV2, DIV4, DIV8, DIV16} sel_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/div_rate_ctrl.sv
// div_rate_ctrl: glitch-free programmable clock divider (/2../16) with handshaked ratio change
//   fin     : clock, rising edge          rst_n   : async active-low reset
//   enable  : run (1) / park (0)          req/sel : ratio-change request and code
//   ack     : one-cycle pulse when the new ratio takes effect
//   cur_sel : active ratio code           tick    : one-cycle strobe per divided period
//   div_out : 50% duty fin/N square wave  busy    : request pending until next period boundary
module div_rate_ctrl #(
  parameter int CNT_W = div_ctrl_pkg::CNT_W
) (
  input  logic       fin,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       req,
  input  logic [1:0] sel,
  output logic       ack,
  output logic [1:0] cur_sel,
  output logic       tick,
  output logic       div_out,
  output logic       busy
);
  import div_ctrl_pkg::*;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_n, mask;
  logic [1:0] pend, pend_n, cur_n;
  logic ack_n, take;
  // low cur_sel+1 bits of cnt all ones marks the last cycle of a divided period
  assign mask = {CNT_W{1'b1}} >> (2'd3 - cur_sel);
  assign tick = (state != IDLE) && ((cnt & mask) == mask);
  assign div_out = cnt[cur_sel];
  assign busy = (state == PEND);
  // req seen during the ack cycle belongs to the request just served
  assign take = req && !ack;
  always_comb begin
    nxt = state;
    cnt_n = cnt + 1'b1;
    cur_n = cur_sel;
    pend_n = pend;
    ack_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        nxt = enable ? RUN : IDLE;
        cur_n = take ? sel : cur_sel;
        ack_n = take;
      end
      RUN: begin
        if (!enable) begin
          nxt = IDLE;
          cnt_n = '0;
        end else if (take && tick) begin
          cur_n = sel;
          cnt_n = '0;
          ack_n = 1'b1;
        end else if (take) begin
          pend_n = sel;
          nxt = PEND;
        end
      end
      PEND: begin
        if (!enable || tick) begin
          cur_n = pend;
          cnt_n = '0;
          ack_n = 1'b1;
          nxt = enable ? RUN : IDLE;
        end
      end
      default: begin
        nxt = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge fin or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      cur_sel <= DIV2;
      pend <= DIV2;
      ack <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
      cur_sel <= cur_n;
      pend <= pend_n;
      ack <= ack_n;
    end
  end
endmodule

// File: tb/tb_div_rate_ctrl.sv
// tb_div_rate_ctrl: directed and random checks of div_rate_ctrl against an arithmetic reference model
module tb_div_rate_ctrl;
  logic fin = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic req = 1'b0;
  logic [1:0] sel = 2'd0;
  logic ack, tick, div_out, busy;
  logic [1:0] cur_sel;
  logic [5:0] obs;
  int n_checks = 0;
  int n_fails = 0;
  bit m_on, m_wait, m_ack;
  int m_cnt, m_cur, m_pend;

  div_rate_ctrl dut (.fin(fin), .rst_n(rst_n), .enable(enable), .req(req), .sel(sel),
                     .ack(ack), .cur_sel(cur_sel), .tick(tick), .div_out(div_out), .busy(busy));

  always #5 fin = ~fin;
  assign obs = {ack, cur_sel, tick, div_out, busy};

  function automatic bit m_tick();
    int n = 2 << m_cur;
    return m_on && ((m_cnt % n) == n - 1);
  endfunction

  function automatic logic [5:0] exp_vec();
    int n = 2 << m_cur;
    return {m_ack, 2'(m_cur), m_tick(), m_on && ((m_cnt % n) >= n / 2), m_wait};
  endfunction

  task automatic m_reset();
    m_on = 0; m_wait = 0; m_ack = 0; m_cnt = 0; m_cur = 0; m_pend = 0;
  endtask

  task automatic step();
    bit t, take;
    @(posedge fin);
    t = m_tick();
    take = req && !m_ack;
    if (!m_on) begin
      m_ack = take;
      if (take) m_cur = sel;
      m_on = enable;
      m_cnt = 0;
    end else if (m_wait) begin
      if (!enable || t) begin
        m_cur = m_pend; m_ack = 1; m_wait = 0; m_cnt = 0; m_on = enable;
      end else begin
        m_cnt = (m_cnt + 1) % 16; m_ack = 0;
      end
    end else if (!enable) begin
      m_on = 0; m_cnt = 0; m_ack = 0;
    end else if (take && t) begin
      m_cur = sel; m_cnt = 0; m_ack = 1;
    end else begin
      if (take) begin m_pend = sel; m_wait = 1; end
      m_cnt = (m_cnt + 1) % 16;
      m_ack = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    if (obs !== 6'd0) begin n_fails++; $display("FAIL reset_async got=%b exp=%b", obs, 6'd0); end
    n_checks++;
    step();
    if (obs !== 6'd0) begin n_fails++; $display("FAIL reset_held got=%b exp=%b", obs, 6'd0); end
    n_checks++;
    rst_n = 1'b1;
    m_reset();
    step();
    if (obs !== exp_vec()) begin n_fails++; $display("FAIL reset_idle got=%b exp=%b", obs, exp_vec()); end
    n_checks++;
  endtask

  task automatic test_div2();
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (obs !== exp_vec()) begin n_fails++; $display("FAIL div2 k=%0d got=%b exp=%b", k, obs, exp_vec()); end
      n_checks++;
      if ({tick, div_out} !== {2{k % 2 == 0}}) begin
        n_fails++; $display("FAIL div2_pattern k=%0d got=%b%b exp=%0d%0d", k, tick, div_out, k % 2 == 0, k % 2 == 0);
      end
      n_checks++;
    end
  endtask

  task automatic test_idle_req();
    int hi = 0, ticks = 0;
    enable = 1'b0;
    step();
    step();
    req = 1'b1; sel = 2'd3;
    step();
    if ({ack, cur_sel} !== 3'b111) begin n_fails++; $display("FAIL idle_req got=%b%b exp=1 11", ack, cur_sel); end
    n_checks++;
    req = 1'b0;
    step();
    if (obs !== exp_vec()) begin n_fails++; $display("FAIL idle_req_after got=%b exp=%b", obs, exp_vec()); end
    n_checks++;
    enable = 1'b1;
    step();
    for (int k = 0; k < 32; k++) begin
      step();
      if (obs !== exp_vec()) begin n_fails++; $display("FAIL div16 k=%0d got=%b exp=%b", k, obs, exp_vec()); end
      n_checks++;
      hi += int'(div_out);
      ticks += int'(tick);
    end
    if (hi != 16 || ticks != 2) begin n_fails++; $display("FAIL div16_shape hi=%0d ticks=%0d exp 16 2", hi, ticks); end
    n_checks++;
  endtask

  task automatic test_pend_switch();
    int busy_n = 0;
    logic d1, d2;
    for (int i = 0; i < 20 && m_cnt != 3; i++) step();
    if (m_cnt != 3) begin n_fails++; $display("FAIL pend_wait cnt=%0d exp 3", m_cnt); end
    n_checks++;
    req = 1'b1; sel = 2'd1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs !== exp_vec()) begin n_fails++; $display("FAIL pend i=%0d got=%b exp=%b", i, obs, exp_vec()); end
      n_checks++;
      busy_n += int'(busy);
      if (ack) break;
    end
    if ({ack, cur_sel, busy_n} !== {1'b1, 2'd1, 12}) begin
      n_fails++; $display("FAIL pend_ack ack=%b cur=%0d busy_cycles=%0d exp 1 1 12", ack, cur_sel, busy_n);
    end
    n_checks++;
    d2 = div_out;
    step();
    if (obs !== exp_vec()) begin n_fails++; $display("FAIL pend_ackcycle got=%b exp=%b", obs, exp_vec()); end
    n_checks++;
    req = 1'b0;
    d1 = div_out;
    for (int k = 0; k < 16; k++) begin
      step();
      if (obs !== exp_vec()) begin n_fails++; $display("FAIL div4 k=%0d got=%b exp=%b", k, obs, exp_vec()); end
      n_checks++;
      if (d1 !== d2 && d1 !== div_out) begin n_fails++; $display("FAIL runt k=%0d got=%b%b%b", k, d2, d1, div_out); end
      n_checks++;
      d2 = d1; d1 = div_out;
    end
  endtask

  task automatic test_tick_switch();
    int busy_n = 0, ticks = 0;
    for (int i = 0; i < 8 && !m_tick(); i++) step();
    if (!m_tick() || tick !== 1'b1) begin n_fails++; $display("FAIL tick_wait tick=%b exp 1", tick); end
    n_checks++;
    req = 1'b1; sel = 2'd2;
    step();
    if ({ack, cur_sel, busy} !== 4'b1100) begin n_fails++; $display("FAIL tick_switch got=%b%b%b exp=1 10 0", ack, cur_sel, busy); end
    n_checks++;
    step();
    req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (obs !== exp_vec()) begin n_fails++; $display("FAIL div8 k=%0d got=%b exp=%b", k, obs, exp_vec()); end
      n_checks++;
      busy_n += int'(busy);
      ticks += int'(tick);
    end
    if (busy_n != 0 || ticks != 2) begin n_fails++; $display("FAIL div8_shape busy=%0d ticks=%0d exp 0 2", busy_n, ticks); end
    n_checks++;
  endtask

  task automatic test_pend_disable();
    for (int i = 0; i < 10 && m_cnt % 8 != 2; i++) step();
    req = 1'b1; sel = 2'd0;
    step();
    if (busy !== 1'b1) begin n_fails++; $display("FAIL pd_busy got=%b exp=1", busy); end
    n_checks++;
    enable = 1'b0;
    step();
    if (obs !== 6'b100000) begin n_fails++; $display("FAIL pend_disable got=%b exp=100000", obs); end
    n_checks++;
    req = 1'b0;
    step();
    if (obs !== exp_vec()) begin n_fails++; $display("FAIL pd_after got=%b exp=%b", obs, exp_vec()); end
    n_checks++;
  endtask

  task automatic test_pend_reset();
    enable = 1'b1;
    step();
    req = 1'b1; sel = 2'd3;
    step();
    if (busy !== 1'b1 || cur_sel !== 2'd0) begin n_fails++; $display("FAIL pr_busy got=%b %0d exp=1 0", busy, cur_sel); end
    n_checks++;
    rst_n = 1'b0;
    #1;
    if (obs !== 6'd0) begin n_fails++; $display("FAIL pr_async got=%b exp=0", obs); end
    n_checks++;
    req = 1'b0;
    step();
    if (obs !== 6'd0) begin n_fails++; $display("FAIL pr_noack got=%b exp=0", obs); end
    n_checks++;
    rst_n = 1'b1;
    m_reset();
    enable = 1'b0;
    step();
    if (obs !== exp_vec()) begin n_fails++; $display("FAIL pr_after got=%b exp=%b", obs, exp_vec()); end
    n_checks++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if (ack) req = 1'b0;
      else if (!req && $urandom_range(0, 3) == 0) begin
        req = 1'b1;
        sel = 2'($urandom_range(0, 3));
      end
      enable = $urandom_range(0, 9) != 0;
      step();
      if (obs !== exp_vec()) begin n_fails++; $display("FAIL random k=%0d got=%b exp=%b", k, obs, exp_vec()); end
      n_checks++;
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_div2();
    test_idle_req();
    test_pend_switch();
    test_tick_switch();
    test_pend_disable();
    test_pend_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
